hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Issue-side producer tracker for the 5-stage core with 8 registers and 3-bit register addresses. It records every in-flight register write and its stage age. It tracks outstanding variable-latency loads, and from that state generates the issue stall. It also produces the registered rs/rt forward-select codes that the execute-stage operand muxes consume. Sits between decode/issue and execute, alongside the operand muxes.

Parameters:
LD_MAX, 2, maximum outstanding loads (1..4); a new load issue stalls when the count equals LD_MAX
NREG, 8, architectural registers; fixed to 8 because addresses are 3 bits

Ports:
clk_i  in  1  core clock
rst_n_i  in  1  asynchronous active-low reset
issue_valid_i  in  1  decode presents an instruction
issue_rs_i  in  3  source A address
issue_rt_i  in  3  source B address
issue_wr_i  in  1  instruction writes a register
issue_dest_i  in  3  destination address
issue_load_i  in  1  instruction is a load
ld_done_i  in  1  memory returns load data this cycle
ld_dest_i  in  3  destination of the returning load
flush_i  in  1  squash all in-flight non-load writes
stall_o  out  1  hold decode; instruction is not accepted
rs_fwd_o  out  2  0=regfile, 1=ALU result, 2=load data
rt_fwd_o  out  2  same encoding for rt
ld_count_o  out  3  outstanding loads

Behaviour:
- Reset (asynchronous, rst_n_i low): every entry is cleared (pending=0, is_load=0, age=0). ld_count_o=0, rs_fwd_o=0, rt_fwd_o=0. stall_o=0 because it is derived from state.
- Register 0 is hardwired zero. It is never marked pending, never stalls and always forwards 0.
- Per-register entry: pending, is_load, age (2 bits). Age meaning: 0=EX, 1=MEM, 2=WB.
- Accept: issue_valid_i && !stall_o. On accept with issue_wr_i and dest!=0:
  - entry[dest] is set to pending=1, is_load=issue_load_i, age=0 on the next edge.
  - On a load accept, ld_count increments.
- ALU entries (pending, !is_load): age increments each cycle and the entry clears the cycle after age==2.
- Load entries: age saturates at 1. The entry clears on the edge where ld_done_i && ld_dest_i==reg, and ld_count decrements on that edge.
- stall_o is combinational and asserts if any of the following holds:
  - A source is pending with is_load=1 and no ld_done_i for that register this cycle (load-use hazard).
  - issue_load_i and ld_count==LD_MAX.
  - issue_wr_i and the dest is a pending load (WAW).
- Forward select is computed at accept and registered, so it is valid when the instruction is in EX:
  - 1 if the source is a pending ALU entry.
  - 2 if the source's load completes this cycle (ld_done_i match).
  - 0 otherwise.
  - When not accepting, the codes are held at 0 (bubble).
- Simultaneous ld_done_i and an accepted issue to the same dest: the new issue wins. The entry is re-marked pending, and ld_count both decrements and increments as applicable (net effect).
- flush_i clears all ALU entries and both forward codes on the next edge. Load entries and ld_count are unaffected. An issue in the same cycle as flush_i is not recorded.
- ld_done_i with no matching pending load is ignored and ld_count does not underflow. ld_count_o is registered.
- Reset asserted mid-load: all state is dropped. Late ld_done_i responses after reset are ignored per the rule above.

Decomposition:
- Shared package: the forward-select constants (FWD_RF=0, FWD_ALU=1, FWD_MEM=2), the age encoding, and the register address width (3).
- One natural sub-module, sb_entry: a single register's pending/is_load/age state machine. It is instantiated 7 times for registers 1..7.
- Stall and forward logic stays in the top level.

Test Plan:
- ALU r3 issued, then next cycle an op with rs=3 -> no stall, rs_fwd_o=1 in EX; entry clears 3 cycles after issue.
- Load r5 issued, then rt=5 consumer -> stall_o=1 until ld_done_i with ld_dest_i=5; in that cycle stall_o=0 and rt_fwd_o=2 next cycle.
- LD_MAX=2: two loads to r1 and r2 outstanding, third load issued -> stall_o=1, ld_count_o=2; ld_done_i for r1 -> accepted next, ld_count_o stays 2.
- Issue to r4 in the same cycle as ld_done_i for r4 -> r4 remains pending (as the new producer), ld_count_o decrements by 1.
- flush_i with ALU r6 pending and load r7 pending -> r6 clears (consumer of r6 sees fwd 0), r7 still stalls consumers, ld_count_o=1.
- Reset asserted with 2 loads outstanding -> ld_count_o=0, stall_o=0; a stray ld_done_i for r2 afterwards -> count stays 0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: register address width,
// forward-select codes, per-register age encoding and entry state.
package hazard_scoreboard_pkg;

  localparam int AW   = 3;
  localparam int NREG = 8;

  typedef logic [AW-1:0] reg_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_ALU = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  typedef enum logic [1:0] {
    AGE_EX  = 2'd0,
    AGE_MEM = 2'd1,
    AGE_WB  = 2'd2
  } age_e;

  typedef struct packed {
    logic pending;
    logic is_load;
    age_e age;
  } entry_t;

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One register's producer state: pending / is_load / age.
// Ports: clk, rst_n, set, set_load, done, flush in; pending, is_load out.
module sb_entry
  import hazard_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic set_load,
  input  logic done,
  input  logic flush,
  output logic pending,
  output logic is_load
);

  entry_t cur;
  entry_t nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= '0;
    else        cur <= nxt;
  end

  // A new producer always wins over a retiring one.
  always_comb begin
    nxt = cur;
    if (set) begin
      nxt.pending = 1'b1;
      nxt.is_load = set_load;
      nxt.age     = AGE_EX;
    end else if (cur.pending) begin
      if (cur.is_load) begin
        if (done) nxt = '0;
        else      nxt.age = AGE_MEM;
      end else if (flush || cur.age == AGE_WB) begin
        nxt = '0;
      end else begin
        nxt.age = age_e'(cur.age + 2'd1);
      end
    end
  end

  always_comb begin
    pending = cur.pending;
    is_load = cur.is_load;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-side producer tracker: issue stall, registered rs/rt forward
// selects and outstanding-load count for an 8-register core.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int LD_MAX = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       issue_valid_i,
  input  reg_t       issue_rs_i,
  input  reg_t       issue_rt_i,
  input  logic       issue_wr_i,
  input  reg_t       issue_dest_i,
  input  logic       issue_load_i,
  input  logic       ld_done_i,
  input  reg_t       ld_dest_i,
  input  logic       flush_i,
  output logic       stall_o,
  output logic [1:0] rs_fwd_o,
  output logic [1:0] rt_fwd_o,
  output logic [2:0] ld_count_o
);

  logic [NREG-1:0] alu_pend;
  logic [NREG-1:0] ld_pend;
  logic [NREG-1:0] hit;
  logic            accept;
  logic            rec;
  logic            use_hz;
  logic            waw_hz;
  logic            max_hz;
  logic [1:0]      rs_sel;
  logic [1:0]      rt_sel;

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    if (g == 0) begin : g_zero
      assign alu_pend[g] = 1'b0;
      assign ld_pend[g]  = 1'b0;
      assign hit[g]      = 1'b0;
    end else begin : g_ent
      logic pend;
      logic isld;
      sb_entry u_entry (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .set      (rec && issue_dest_i == reg_t'(g)),
        .set_load (issue_load_i),
        .done     (hit[g]),
        .flush    (flush_i),
        .pending  (pend),
        .is_load  (isld)
      );
      assign alu_pend[g] = pend && !isld;
      assign ld_pend[g]  = pend && isld;
      // Only a pending load can retire; stray returns fall out here.
      assign hit[g] = ld_done_i
                   && ld_dest_i == reg_t'(g)
                   && ld_pend[g];
    end
  end

  assign use_hz = (ld_pend[issue_rs_i] && !hit[issue_rs_i])
               || (ld_pend[issue_rt_i] && !hit[issue_rt_i]);
  assign max_hz = issue_load_i && ld_count_o == 3'(LD_MAX);
  assign waw_hz = issue_wr_i
               && ld_pend[issue_dest_i]
               && !hit[issue_dest_i];
  assign stall_o = use_hz || max_hz || waw_hz;

  assign accept = issue_valid_i && !stall_o;
  assign rec    = accept && issue_wr_i
               && issue_dest_i != '0 && !flush_i;

  always_comb begin
    rs_sel = FWD_RF;
    unique case (1'b1)
      alu_pend[issue_rs_i]: rs_sel = FWD_ALU;
      hit[issue_rs_i]:      rs_sel = FWD_MEM;
      default: ;
    endcase
  end

  always_comb begin
    rt_sel = FWD_RF;
    unique case (1'b1)
      alu_pend[issue_rt_i]: rt_sel = FWD_ALU;
      hit[issue_rt_i]:      rt_sel = FWD_MEM;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rs_fwd_o   <= FWD_RF;
      rt_fwd_o   <= FWD_RF;
      ld_count_o <= '0;
    end else begin
      if (accept && !flush_i) begin
        rs_fwd_o <= rs_sel;
        rt_fwd_o <= rt_sel;
      end else begin
        rs_fwd_o <= FWD_RF;
        rt_fwd_o <= FWD_RF;
      end
      ld_count_o <= ld_count_o
                  + 3'(rec && issue_load_i)
                  - 3'(|hit);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus
// random traffic against a producer-list reference model.
module tb_hazard_scoreboard;

  localparam int LD_MAX = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v;
  logic [2:0] rs;
  logic [2:0] rt;
  logic       wr;
  logic [2:0] dest;
  logic       ld;
  logic       done;
  logic [2:0] ldd;
  logic       flush;
  logic       stall;
  logic [1:0] rs_fwd;
  logic [1:0] rt_fwd;
  logic [2:0] ld_count;

  int vectors = 0;
  int errors  = 0;

  // Reference: ALU producers live 3 edges after their issue edge;
  // loads are an outstanding set whose size is the load count.
  bit         alu_v [8];
  int         alu_born [8];
  bit         ld_out [8];
  int         now;
  logic [1:0] e_rs;
  logic [1:0] e_rt;

  always #5 clk = ~clk;

  hazard_scoreboard #(.LD_MAX(LD_MAX)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .issue_valid_i (v),
    .issue_rs_i    (rs),
    .issue_rt_i    (rt),
    .issue_wr_i    (wr),
    .issue_dest_i  (dest),
    .issue_load_i  (ld),
    .ld_done_i     (done),
    .ld_dest_i     (ldd),
    .flush_i       (flush),
    .stall_o       (stall),
    .rs_fwd_o      (rs_fwd),
    .rt_fwd_o      (rt_fwd),
    .ld_count_o    (ld_count)
  );

  function automatic bit m_alu(input logic [2:0] r);
    return r != 0 && alu_v[r] && (now - alu_born[r]) < 3;
  endfunction

  function automatic bit m_busy(input logic [2:0] r);
    return r != 0 && ld_out[r] && !(done && ldd == r);
  endfunction

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(ld_out[i]);
    return n;
  endfunction

  function automatic bit m_stall();
    return m_busy(rs) || m_busy(rt)
        || (ld && m_cnt() == LD_MAX)
        || (wr && m_busy(dest));
  endfunction

  function automatic logic [1:0] m_fwd(input logic [2:0] r,
                                       input bit hit);
    if (m_alu(r)) return 2'd1;
    if (hit && ldd == r) return 2'd2;
    return 2'd0;
  endfunction

  task automatic idle();
    v = 0; rs = 0; rt = 0; wr = 0; dest = 0;
    ld = 0; done = 0; ldd = 0; flush = 0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      alu_v[i] = 0; ld_out[i] = 0; alu_born[i] = 0;
    end
    now = 0; e_rs = 0; e_rt = 0;
  endtask

  task automatic tick();
    bit acc, hit, rec;
    logic [1:0] nrs, nrt;
    acc = v && !m_stall();
    hit = done && ldd != 0 && ld_out[ldd];
    rec = acc && wr && dest != 0 && !flush;
    nrs = 0; nrt = 0;
    if (acc && !flush) begin
      nrs = m_fwd(rs, hit);
      nrt = m_fwd(rt, hit);
    end
    @(posedge clk);
    now++;
    if (hit) ld_out[ldd] = 0;
    if (flush) for (int i = 0; i < 8; i++) alu_v[i] = 0;
    if (rec) begin
      if (ld) begin
        ld_out[dest] = 1; alu_v[dest] = 0;
      end else begin
        alu_v[dest] = 1; alu_born[dest] = now; ld_out[dest] = 0;
      end
    end
    e_rs = nrs; e_rt = nrt;
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    model_clear();
    #3;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic issue(input logic [2:0] d, input logic isld);
    idle(); v = 1; wr = 1; dest = d; ld = isld;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors += 4;
    if (ld_count !== 3'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d expected 0", ld_count);
    end
    if (rs_fwd !== 2'd0) begin
      errors++; $display("FAIL reset_rs: got %0d expected 0", rs_fwd);
    end
    if (rt_fwd !== 2'd0) begin
      errors++; $display("FAIL reset_rt: got %0d expected 0", rt_fwd);
    end
    if (stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %0d expected 0", stall);
    end
  endtask

  task automatic test_alu_fwd();
    do_reset();
    issue(3'd3, 0); tick();
    idle(); v = 1; rs = 3; #1;
    vectors++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL alu_stall: got %0d expected 0", stall);
    end
    tick();
    vectors++;
    if (rs_fwd !== 2'd1) begin
      errors++; $display("FAIL alu_fwd: got %0d expected 1", rs_fwd);
    end
    idle(); tick(); tick();
    idle(); v = 1; rs = 3; tick();
    vectors++;
    if (rs_fwd !== 2'd0) begin
      errors++; $display("FAIL alu_clear: got %0d expected 0", rs_fwd);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(3'd5, 1); tick();
    idle(); v = 1; rt = 5;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors += 2;
      if (stall !== 1'b1) begin
        errors++; $display("FAIL lu_stall: got %0d expected 1", stall);
      end
      if (ld_count !== 3'd1) begin
        errors++; $display("FAIL lu_cnt: got %0d expected 1", ld_count);
      end
      tick();
    end
    done = 1; ldd = 5; #1;
    vectors++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL lu_done: got %0d expected 0", stall);
    end
    tick();
    vectors += 2;
    if (rt_fwd !== 2'd2) begin
      errors++; $display("FAIL lu_fwd: got %0d expected 2", rt_fwd);
    end
    if (ld_count !== 3'd0) begin
      errors++; $display("FAIL lu_cnt0: got %0d expected 0", ld_count);
    end
  endtask

  task automatic test_ld_max();
    do_reset();
    issue(3'd1, 1); tick();
    issue(3'd2, 1); tick();
    issue(3'd6, 1); #1;
    vectors += 2;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL max_stall: got %0d expected 1", stall);
    end
    if (ld_count !== 3'd2) begin
      errors++; $display("FAIL max_cnt: got %0d expected 2", ld_count);
    end
    done = 1; ldd = 1; #1;
    vectors++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL max_done_stall: got %0d expected 1", stall);
    end
    tick();
    issue(3'd6, 1); #1;
    vectors++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL max_accept: got %0d expected 0", stall);
    end
    tick();
    vectors++;
    if (ld_count !== 3'd2) begin
      errors++; $display("FAIL max_cnt2: got %0d expected 2", ld_count);
    end
  endtask

  task automatic test_same_dest();
    do_reset();
    issue(3'd4, 1); tick();
    issue(3'd4, 0); done = 1; ldd = 4; #1;
    vectors++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL same_stall: got %0d expected 0", stall);
    end
    tick();
    vectors++;
    if (ld_count !== 3'd0) begin
      errors++; $display("FAIL same_cnt: got %0d expected 0", ld_count);
    end
    idle(); v = 1; rs = 4; tick();
    vectors++;
    if (rs_fwd !== 2'd1) begin
      errors++; $display("FAIL same_fwd: got %0d expected 1", rs_fwd);
    end
  endtask

  task automatic test_flush();
    do_reset();
    issue(3'd7, 1); tick();
    issue(3'd6, 0); tick();
    idle(); flush = 1; tick();
    idle(); v = 1; rs = 6; rt = 7; #1;
    vectors++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL fl_ld_stall: got %0d expected 1", stall);
    end
    rt = 0; #1;
    vectors++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL fl_alu_stall: got %0d expected 0", stall);
    end
    tick();
    vectors += 2;
    if (rs_fwd !== 2'd0) begin
      errors++; $display("FAIL fl_fwd: got %0d expected 0", rs_fwd);
    end
    if (ld_count !== 3'd1) begin
      errors++; $display("FAIL fl_cnt: got %0d expected 1", ld_count);
    end
    issue(3'd2, 0); flush = 1; tick();
    idle(); v = 1; rs = 2; tick();
    vectors++;
    if (rs_fwd !== 2'd0) begin
      errors++; $display("FAIL fl_issue: got %0d expected 0", rs_fwd);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    issue(3'd2, 1); tick();
    issue(3'd3, 1); tick();
    idle(); #1;
    vectors++;
    if (ld_count !== 3'd2) begin
      errors++; $display("FAIL rml_cnt2: got %0d expected 2", ld_count);
    end
    rst_n = 0; #1;
    model_clear();
    vectors += 2;
    if (ld_count !== 3'd0) begin
      errors++; $display("FAIL rml_cnt0: got %0d expected 0", ld_count);
    end
    if (stall !== 1'b0) begin
      errors++; $display("FAIL rml_stall: got %0d expected 0", stall);
    end
    @(negedge clk); rst_n = 1;
    done = 1; ldd = 2; v = 1; rs = 2; #1;
    vectors++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL rml_stray_stall: got %0d expected 0", stall);
    end
    tick();
    vectors++;
    if (ld_count !== 3'd0) begin
      errors++; $display("FAIL rml_stray_cnt: got %0d expected 0", ld_count);
    end
  endtask

  task automatic test_random();
    int exp_c;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v     = $urandom_range(0, 3) != 0;
      rs    = 3'($urandom_range(0, 7));
      rt    = 3'($urandom_range(0, 7));
      wr    = $urandom_range(0, 3) != 0;
      dest  = 3'($urandom_range(0, 7));
      ld    = $urandom_range(0, 2) == 0;
      done  = $urandom_range(0, 2) == 0;
      ldd   = 3'($urandom_range(0, 7));
      flush = $urandom_range(0, 15) == 0;
      #1;
      vectors++;
      if (stall !== m_stall()) begin
        errors++;
        $display("FAIL rnd_stall @%0d: got %0d expected %0d",
                 n, stall, m_stall());
      end
      tick();
      exp_c = m_cnt();
      vectors += 3;
      if (rs_fwd !== e_rs) begin
        errors++;
        $display("FAIL rnd_rs @%0d: got %0d expected %0d", n, rs_fwd, e_rs);
      end
      if (rt_fwd !== e_rt) begin
        errors++;
        $display("FAIL rnd_rt @%0d: got %0d expected %0d", n, rt_fwd, e_rt);
      end
      if (int'(ld_count) != exp_c) begin
        errors++;
        $display("FAIL rnd_cnt @%0d: got %0d expected %0d",
                 n, ld_count, exp_c);
      end
    end
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_clear();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_ld_max();
    test_same_dest();
    test_flush();
    test_reset_mid_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
